// File: rtl/cram_arbiter.sv
// cram_arbiter: two-requester arbiter in front of a single CRAM controller port.
//
// Requester A (bridge-side loader) has fixed priority over requester B (core
// fetch), but after MAX_A_RUN consecutive A grants made while B was waiting,
// B is granted next. Only one transaction is outstanding at a time. A
// watchdog aborts a read that receives no mem_rvalid within RD_TIMEOUT
// cycles and returns all-ones data.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   a_valid/a_write/a_addr/a_wdata    requester A command
//   a_ready, a_rvalid                 A accept pulse, A read-data pulse
//   b_*                               requester B, same as A
//   rdata                             shared read data, held between pulses
//   mem_req/mem_we/mem_addr/mem_wdata request to the CRAM controller
//   mem_ack, mem_rvalid, mem_rdata    controller accept and read return
//   rd_timeout                        one-cycle pulse when a read is aborted
//   busy                              a transaction is in flight
//
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.
module cram_arbiter #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_A_RUN  = 4,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              a_valid,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,

    input  logic              b_valid,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              rd_timeout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT
    } state_t;

    localparam logic [3:0] RUN_MAX  = 4'(MAX_A_RUN);
    localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_b_q, owner_b_d;   // 1: B owns the transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        a_run_q, a_run_d;
    logic [7:0]        timer_q, timer_d;
    logic              a_ready_q, a_ready_d;
    logic              b_ready_q, b_ready_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tmo_q, tmo_d;
    logic              grant_a, grant_b;

    always_comb begin
        state_d    = state_q;
        owner_b_d  = owner_b_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_run_d    = a_run_q;
        timer_d    = timer_q;
        rdata_d    = rdata_q;
        a_ready_d  = 1'b0;
        b_ready_d  = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        tmo_d      = 1'b0;
        grant_a    = 1'b0;
        grant_b    = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                // While a ready pulse is on the wire the requester still holds
                // valid for the request just accepted; granting now would
                // accept it a second time, so this cycle is always a gap.
                if (!(a_ready_q || b_ready_q)) begin
                    grant_a = a_valid && !(b_valid && (a_run_q == RUN_MAX));
                    grant_b = !grant_a && b_valid;
                end
                if (grant_a) begin
                    owner_b_d = 1'b0;
                    we_d      = a_write;
                    addr_d    = a_addr;
                    wdata_d   = a_wdata;
                    state_d   = ISSUE;
                    if (!b_valid) begin
                        a_run_d = '0;
                    end else if (a_run_q != RUN_MAX) begin
                        a_run_d = a_run_q + 4'd1;
                    end
                end else if (grant_b) begin
                    owner_b_d = 1'b1;
                    we_d      = b_write;
                    addr_d    = b_addr;
                    wdata_d   = b_wdata;
                    state_d   = ISSUE;
                    a_run_d   = '0;
                end
            end

            ISSUE: begin
                if (mem_ack) begin
                    a_ready_d = !owner_b_q;
                    b_ready_d = owner_b_q;
                    if (we_q) begin
                        state_d = IDLE;
                    end else if (mem_rvalid) begin
                        // ack and data together: finish the read right away
                        rdata_d    = mem_rdata;
                        a_rvalid_d = !owner_b_q;
                        b_rvalid_d = owner_b_q;
                        state_d    = IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d    = mem_rdata;
                    a_rvalid_d = !owner_b_q;
                    b_rvalid_d = owner_b_q;
                    state_d    = IDLE;
                end else if (timer_q == TMO_LAST) begin
                    rdata_d    = '1;
                    a_rvalid_d = !owner_b_q;
                    b_rvalid_d = owner_b_q;
                    tmo_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_b_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_run_q    <= '0;
            timer_q    <= '0;
            a_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            rdata_q    <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_b_q  <= owner_b_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            a_run_q    <= a_run_d;
            timer_q    <= timer_d;
            a_ready_q  <= a_ready_d;
            b_ready_q  <= b_ready_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
        end
    end

    assign mem_req    = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign a_ready    = a_ready_q;
    assign b_ready    = b_ready_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign rdata      = rdata_q;
    assign rd_timeout = tmo_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// Bench for cram_arbiter: directed scenarios plus a transaction-level model
// that predicts every output, checked on each falling clock edge.
module tb_cram_arbiter;

    localparam int AW   = 22;
    localparam int DW   = 16;
    localparam int MAXR = 4;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_valid = 1'b0, a_write = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_valid = 1'b0, b_write = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          mem_ack_man = 1'b0, auto_ack = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    wire           mem_ack;

    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          rd_timeout, busy;

    always #5 clk = ~clk;

    // controller stand-in: either a scripted ack or an ack on every request
    assign mem_ack = mem_ack_man | (auto_ack & mem_req);

    cram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_A_RUN(MAXR),
        .RD_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid),
        .b_valid(b_valid), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd_timeout(rd_timeout), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One outstanding transaction: it is open from grant until it completes,
    // "acked" once the controller took it, and for reads "waited" counts the
    // cycles spent waiting for data afterwards.
    bit            m_open, m_acked, m_owner_b, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_waited, m_arun;
    logic          e_ar, e_br, e_av, e_bv, e_to;
    logic [DW-1:0] e_rdata;

    always @(posedge clk or negedge reset_n) begin
        bit gap, pick_a;
        if (!reset_n) begin
            m_open = 0; m_acked = 0; m_owner_b = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_waited = 0; m_arun = 0;
            e_ar = 0; e_br = 0; e_av = 0; e_bv = 0; e_to = 0; e_rdata = '0;
        end else begin
            gap = e_ar | e_br;
            e_ar = 0; e_br = 0; e_av = 0; e_bv = 0; e_to = 0;
            if (!m_open) begin
                if (!gap && (a_valid || b_valid)) begin
                    pick_a = a_valid && !(b_valid && m_arun == MAXR);
                    if (pick_a) begin
                        m_owner_b = 0; m_we = a_write; m_addr = a_addr; m_wdata = a_wdata;
                        if (!b_valid) m_arun = 0;
                        else if (m_arun < MAXR) m_arun++;
                    end else begin
                        m_owner_b = 1; m_we = b_write; m_addr = b_addr; m_wdata = b_wdata;
                        m_arun = 0;
                    end
                    m_open = 1; m_acked = 0;
                end
            end else if (!m_acked) begin
                if (mem_ack) begin
                    if (m_owner_b) e_br = 1; else e_ar = 1;
                    if (m_we) begin
                        m_open = 0;
                    end else if (mem_rvalid) begin
                        e_rdata = mem_rdata;
                        if (m_owner_b) e_bv = 1; else e_av = 1;
                        m_open = 0;
                    end else begin
                        m_acked = 1; m_waited = 0;
                    end
                end
            end else begin
                m_waited++;
                if (mem_rvalid) begin
                    e_rdata = mem_rdata;
                    if (m_owner_b) e_bv = 1; else e_av = 1;
                    m_open = 0;
                end else if (m_waited == TMO) begin
                    e_rdata = '1; e_to = 1;
                    if (m_owner_b) e_bv = 1; else e_av = 1;
                    m_open = 0;
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("a_ready",    32'(a_ready),    32'(e_ar));
        chk("b_ready",    32'(b_ready),    32'(e_br));
        chk("a_rvalid",   32'(a_rvalid),   32'(e_av));
        chk("b_rvalid",   32'(b_rvalid),   32'(e_bv));
        chk("rd_timeout", 32'(rd_timeout), 32'(e_to));
        chk("busy",       32'(busy),       32'(m_open));
        chk("mem_req",    32'(mem_req),    32'(m_open && !m_acked));
        chk("rdata",      32'(rdata),      32'(e_rdata));
        if (m_open && !m_acked) begin
            chk("mem_we",    32'(mem_we),    32'(m_we));
            chk("mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name, output int n);
        n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        chk(name, 32'(mem_req), 32'd1);
    endtask

    initial begin
        int    n;
        string order;

        tick(); tick();
        chk("reset_busy",  32'(busy),    32'd0);
        chk("reset_rdata", 32'(rdata),   32'd0);
        chk("reset_req",   32'(mem_req), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: A write, ack after 3 cycles of mem_req
        a_valid = 1; a_write = 1; a_addr = 22'h000010; a_wdata = 16'hBEEF;
        wait_req("t1_req", n);
        chk("t1_grant_latency", 32'(n), 32'd1);
        chk("t1_we",    32'(mem_we),    32'd1);
        chk("t1_addr",  32'(mem_addr),  32'h10);
        chk("t1_wdata", 32'(mem_wdata), 32'hBEEF);
        tick(); tick(); tick();
        chk("t1_req_held", 32'(mem_req), 32'd1);
        mem_ack_man = 1;
        tick();
        mem_ack_man = 0;
        chk("t1_a_ready", 32'(a_ready), 32'd1);
        chk("t1_b_ready", 32'(b_ready), 32'd0);
        chk("t1_req_drop", 32'(mem_req), 32'd0);
        tick();
        a_valid = 0;
        chk("t1_ready_once", 32'(a_ready), 32'd0);
        tick();

        // 2: B read at 0x1234, data 5 cycles after ack
        b_valid = 1; b_write = 0; b_addr = 22'h001234;
        wait_req("t2_req", n);
        mem_ack_man = 1;
        tick();
        mem_ack_man = 0;
        chk("t2_b_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 0;
        tick(); tick(); tick();
        mem_rvalid = 1; mem_rdata = 16'h5A5A;
        tick();
        mem_rvalid = 0;
        chk("t2_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("t2_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("t2_rdata",    32'(rdata),    32'h5A5A);
        tick();
        chk("t2_rvalid_once", 32'(b_rvalid), 32'd0);
        chk("t2_rdata_hold",  32'(rdata),    32'h5A5A);

        // 3: both requesters continuously valid, immediate ack
        auto_ack = 1;
        a_valid = 1; a_write = 1; a_addr = 22'h100; a_wdata = 16'h0A0A;
        b_valid = 1; b_write = 1; b_addr = 22'h200; b_wdata = 16'h0B0B;
        order = "";
        n = 0;
        while (order.len() < 10 && n < 60) begin
            tick();
            n++;
            if (a_ready) begin order = {order, "A"}; a_addr = a_addr + 1; end
            if (b_ready) begin order = {order, "B"}; b_addr = b_addr + 1; end
        end
        tick();
        a_valid = 0; b_valid = 0; auto_ack = 0;
        checks++;
        if (order != "AAAABAAAAB") begin
            errors++;
            $display("FAIL t3_order: got %s expected AAAABAAAAB", order);
        end
        tick(); tick();

        // 4: B read never returns data, watchdog fires
        b_valid = 1; b_write = 0; b_addr = 22'h002222;
        wait_req("t4_req", n);
        mem_ack_man = 1;
        tick();
        mem_ack_man = 0;
        chk("t4_b_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 0;
        n = 1;
        while (!rd_timeout && n < 30) begin
            tick();
            n++;
        end
        chk("t4_tmo_cycles", 32'(n),        32'd8);
        chk("t4_b_rvalid",   32'(b_rvalid), 32'd1);
        chk("t4_a_rvalid",   32'(a_rvalid), 32'd0);
        chk("t4_rdata",      32'(rdata),    32'hFFFF);
        tick();
        mem_rvalid = 1; mem_rdata = 16'h1111;
        tick();
        mem_rvalid = 0;
        tick();
        chk("t4_late_ignored", 32'(b_rvalid), 32'd0);
        chk("t4_late_rdata",   32'(rdata),    32'hFFFF);
        chk("t4_idle",         32'(busy),     32'd0);

        // 5: A read with ack and data in the same cycle
        a_valid = 1; a_write = 0; a_addr = 22'h000030;
        wait_req("t5_req", n);
        mem_ack_man = 1; mem_rvalid = 1; mem_rdata = 16'h00C3;
        tick();
        mem_ack_man = 0; mem_rvalid = 0;
        chk("t5_a_ready",  32'(a_ready),  32'd1);
        chk("t5_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("t5_rdata",    32'(rdata),    32'h00C3);
        chk("t5_idle",     32'(busy),     32'd0);
        tick();
        a_write = 1; a_addr = 22'h000044; a_wdata = 16'h4444;
        tick();
        chk("t5_next_req",  32'(mem_req),  32'd1);
        chk("t5_next_addr", 32'(mem_addr), 32'h44);
        mem_ack_man = 1;
        tick();
        mem_ack_man = 0;
        tick();
        a_valid = 0;
        tick();

        // 6: reset while waiting for read data
        a_valid = 1; a_write = 0; a_addr = 22'h000055;
        wait_req("t6_req", n);
        mem_ack_man = 1;
        tick();
        mem_ack_man = 0;
        tick();
        a_valid = 0;
        tick();
        chk("t6_in_wait", 32'(busy), 32'd1);
        reset_n = 0;
        #1;
        chk("t6_rst_busy",  32'(busy),     32'd0);
        chk("t6_rst_req",   32'(mem_req),  32'd0);
        chk("t6_rst_rv",    32'(a_rvalid), 32'd0);
        chk("t6_rst_rdata", 32'(rdata),    32'd0);
        chk("t6_rst_addr",  32'(mem_addr), 32'd0);
        tick();
        reset_n = 1;
        mem_rvalid = 1; mem_rdata = 16'h9999;
        tick();
        mem_rvalid = 0;
        tick();
        chk("t6_no_rvalid", 32'(a_rvalid), 32'd0);
        a_valid = 1; a_write = 1; a_addr = 22'h000077; a_wdata = 16'h1357;
        wait_req("t6_req2", n);
        chk("t6_addr2",  32'(mem_addr),  32'h77);
        chk("t6_wdata2", 32'(mem_wdata), 32'h1357);
        mem_ack_man = 1;
        tick();
        mem_ack_man = 0;
        chk("t6_a_ready2", 32'(a_ready), 32'd1);
        tick();
        a_valid = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/cram_arbiter.md
Name: cram_arbiter

Overview:
- Two-requester arbiter sharing one CRAM controller port, i.e. the cram0 datapath. Requester A is the bridge-side ROM/hiscore loader on the bridge clock domain. Requester B is the core-side game fetch, already synchronised to the same clock.
- Only one transaction is outstanding at a time. Priority is fixed in favour of A, with a starvation guard that forces a grant to B after a run of consecutive A grants.
- A timeout watchdog guards read returns.

Parameters:
- ADDR_W, 22, word address width
- DATA_W, 16, data width
- MAX_A_RUN, 4, max consecutive A grants while B is pending (1..15)
- RD_TIMEOUT, 255, cycles to wait for mem_rvalid before aborting a read (1..255)

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- a_valid  in  1  A request valid
- a_write  in  1  A request is write
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_ready  out  1  A request accepted (one-cycle pulse)
- a_rvalid  out  1  A read data valid (one-cycle pulse)
- b_valid, b_write, b_addr, b_wdata, b_ready, b_rvalid  as for A
- rdata  out  DATA_W  read data, shared by both requesters, qualified by a_rvalid or b_rvalid
- mem_req  out  1  request to CRAM controller
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  controller accepted the request
- mem_rvalid  in  1  read data return
- mem_rdata  in  DATA_W  read data
- rd_timeout  out  1  one-cycle pulse on read abort
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release). All outputs are 0. FSM goes to IDLE, a_run=0, timer=0.
- Requester rules:
  - Holds valid, write, addr and wdata stable until ready.
  - Must not drop valid before ready.
  - May present the next request immediately after ready.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Grant rule: choose A if a_valid and not (b_valid and a_run==MAX_A_RUN); otherwise choose B if b_valid.
  - On a grant, register the request fields and owner into mem_* and go to ISSUE. mem_req=1 in the next cycle.
  - No input-to-output combinational path.
- a_run counter:
  - Increments on each A grant while b_valid=1, saturating at MAX_A_RUN.
  - Clears on any B grant.
  - Clears on an A grant with b_valid=0.
- ISSUE:
  - mem_req is held with stable fields until mem_ack.
  - On mem_ack: pulse the owner's ready in the same cycle as mem_ack (registered from the ack edge, so visible the following cycle; one-cycle pulse). Deassert mem_req the cycle after the ack.
  - On mem_ack, writes go to IDLE and reads go to RD_WAIT.
  - mem_ack and mem_rvalid in the same cycle: treat as ack followed by immediate return. Complete the read directly and go to IDLE.
- RD_WAIT:
  - On mem_rvalid: latch rdata=mem_rdata, pulse the owner's rvalid for 1 cycle, go to IDLE.
  - The timer counts cycles in RD_WAIT. When it reaches RD_TIMEOUT: pulse rd_timeout, pulse the owner's rvalid with rdata=all-ones, go to IDLE.
  - A late mem_rvalid arriving in IDLE is ignored.
- Latency:
  - Minimum accept latency from valid to ready: 2 cycles (IDLE grant → ISSUE with mem_ack=1).
  - Read data appears 1 cycle after mem_rvalid.
  - Back-to-back throughput: one transaction per 3 cycles at minimum (grant, issue, idle).
- Simultaneous a_valid and b_valid in IDLE: A wins unless a_run==MAX_A_RUN.
- Valid dropped while not owner: no effect.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. No ready or rvalid is generated for the aborted transaction, and the requester must re-issue.
- rdata holds its last value between pulses.
- busy=1 in ISSUE and RD_WAIT.

Test Plan:
- Single A write, addr=0x000010, data=0xBEEF, mem_ack after 3 cycles → mem_we=1 with the stable fields. a_ready pulses once. mem_req drops the next cycle. b_ready stays 0.
- Single B read at 0x1234, mem_rvalid after 5 cycles with 0x5A5A → rdata=0x5A5A, b_rvalid is a single pulse, a_rvalid stays 0.
- A and B continuously valid, MAX_A_RUN=4, mem_ack immediate → grant order A,A,A,A,B,A,A,A,A,B.
- B read with no mem_rvalid, RD_TIMEOUT=8 → rd_timeout and b_rvalid pulse together 8 cycles into RD_WAIT with rdata=0xFFFF. A mem_rvalid injected later is ignored.
- mem_ack and mem_rvalid in the same cycle for an A read of 0x00C3 → a_ready and a_rvalid both pulse, FSM returns to IDLE, next grant is possible the following cycle.
- reset_n pulsed low while in RD_WAIT → all outputs 0 immediately, no rvalid. After release, a new A write completes normally.
